// File: rtl/midi_uart_rx_if.sv
// midi_uart_rx_if: parsed-message bus out of the MIDI receiver.
//   status    - status byte of the last completed message
//   data1     - first data byte of the last completed message
//   data2     - second data byte (0x00 for 1-data-byte messages)
//   msg_valid - one-cycle pulse when status/data1/data2 update
//   frame_err - one-cycle pulse when a stop bit is sampled low
// master: the receiver drives everything; slave: bus side / synth core.
`timescale 1ns/1ps
interface midi_uart_rx_if #(
    parameter int unsigned REG_WIDTH = 8
);
    logic [REG_WIDTH-1:0] status;
    logic [REG_WIDTH-1:0] data1;
    logic [REG_WIDTH-1:0] data2;
    logic                 msg_valid;
    logic                 frame_err;

    modport master (
        output status,
        output data1,
        output data2,
        output msg_valid,
        output frame_err
    );

    modport slave (
        input status,
        input data1,
        input data2,
        input msg_valid,
        input frame_err
    );
endinterface

// File: rtl/midi_uart_rx.sv
// midi_uart_rx: serial MIDI receiver. Deserializes the 8N1 UART stream and
// parses channel-voice messages (running status supported) into
// status/data1/data2 with a one-cycle msg_valid strobe.
// Ports:
//   clk       - system clock
//   rst       - asynchronous, active-high reset
//   midi_rx_i - raw MIDI serial line, idle high, asynchronous to clk
//   bus       - midi_uart_rx_if.master: status, data1, data2, msg_valid, frame_err
`timescale 1ns/1ps
module midi_uart_rx #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD      = 31250,
    parameter int unsigned REG_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           midi_rx_i,
    midi_uart_rx_if.master bus
);

    localparam int unsigned CPB   = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W = (CPB > 2) ? $clog2(CPB) : 2;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CPB / 2) - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CPB - 1);

    if (CPB < 4) begin : g_cpb_check
        $error("midi_uart_rx: CLK_FREQ/BAUD must be at least 4");
    end
    if (REG_WIDTH != 8) begin : g_width_check
        $error("midi_uart_rx: only REG_WIDTH = 8 is supported");
    end

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // UART side
    logic             rx_meta_q;
    logic             rxs_q;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             frame_err_q;

    // Parser side
    logic [7:0] run_status_q;
    logic       has_status_q;
    logic       byte_cnt_q;
    logic [7:0] data1_buf_q;
    logic [7:0] status_q;
    logic [7:0] data1_q;
    logic [7:0] data2_q;
    logic       msg_valid_q;

    // The stop-bit sample cycle; a good stop hands the byte to the parser on
    // this same edge so the commit lands exactly one clock after the sample.
    logic byte_done;
    logic one_byte_type;

    assign byte_done     = (state_q == StStop) && (cnt_q == CNT_FULL) && rxs_q;
    // Cx (program change) and Dx (channel pressure) carry one data byte.
    assign one_byte_type = (run_status_q[7:5] == 3'b110);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= midi_rx_i;
            rxs_q       <= rx_meta_q;
            frame_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!rxs_q) begin
                        cnt_q   <= '0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        // Line back high at mid-start: a glitch, not a frame.
                        state_q   <= rxs_q ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q   <= '0;
                        shift_q <= {rxs_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= StStop;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q       <= '0;
                        frame_err_q <= !rxs_q;
                        state_q     <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_status_q <= '0;
            has_status_q <= 1'b0;
            byte_cnt_q   <= 1'b0;
            data1_buf_q  <= '0;
            status_q     <= '0;
            data1_q      <= '0;
            data2_q      <= '0;
            msg_valid_q  <= 1'b0;
        end else begin
            msg_valid_q <= 1'b0;
            if (byte_done) begin
                if (shift_q[7:3] == 5'b11111) begin
                    // Real-time bytes may interleave anywhere; leave state alone.
                end else if (shift_q[7:4] == 4'hF) begin
                    has_status_q <= 1'b0;
                    byte_cnt_q   <= 1'b0;
                end else if (shift_q[7]) begin
                    run_status_q <= shift_q;
                    has_status_q <= 1'b1;
                    byte_cnt_q   <= 1'b0;
                end else if (has_status_q) begin
                    if (!byte_cnt_q) begin
                        if (one_byte_type) begin
                            status_q    <= run_status_q;
                            data1_q     <= shift_q;
                            data2_q     <= 8'h00;
                            msg_valid_q <= 1'b1;
                        end else begin
                            data1_buf_q <= shift_q;
                            byte_cnt_q  <= 1'b1;
                        end
                    end else begin
                        status_q    <= run_status_q;
                        data1_q     <= data1_buf_q;
                        data2_q     <= shift_q;
                        msg_valid_q <= 1'b1;
                        byte_cnt_q  <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.status    = status_q;
    assign bus.data1     = data1_q;
    assign bus.data2     = data2_q;
    assign bus.msg_valid = msg_valid_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: doc/midi_uart_rx.md
Name: midi_uart_rx

Overview:
- Serial MIDI receiver: deserializes the 31250-baud MIDI UART stream and parses channel-voice messages into status/data1/data2.
- Inbound counterpart of the Wishbone MIDI register block, which only accepts status/data bytes written from the bus.
- The parsed message plus a one-cycle valid strobe feed the bus side or a synth core.
- Single clock domain; the serial input is asynchronous to clk.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 31250, MIDI bit rate.
- REG_WIDTH, 8, width of the status/data outputs. Only 8 is supported.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- midi_rx_i  input  1  raw MIDI serial line; idle high; asynchronous to clk
- status  output  REG_WIDTH  status byte of the last completed message
- data1  output  REG_WIDTH  first data byte of the last completed message
- data2  output  REG_WIDTH  second data byte; 0x00 for 1-data-byte messages
- msg_valid  output  1  one-cycle pulse when status/data1/data2 update
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low

Behaviour:
- Bit period: CPB = CLK_FREQ/BAUD, integer division. CPB must be >= 4; this is checked by an elaboration assertion.
- Reset: all outputs are 0. UART FSM goes to IDLE, parser has no running status, byte count is 0, and both synchronizer flops are set to 1.
  - Reset takes effect immediately, including mid-frame or mid-message. Any partial frame or message is dropped.
- Input: 2-flop synchronizer. All logic below uses the synchronized signal rxs.
- UART FSM:
  - IDLE: on rxs==0, clear the bit counter and go to START.
  - START: at count CPB/2 - 1, sample rxs. If 0, go to DATA and clear the counter. If 1, treat it as a glitch and return to IDLE with no output.
  - DATA: sample every CPB cycles from the start midpoint. 8 bits, LSB first, shifted into the byte register. After bit 7, go to STOP.
  - STOP: sample at the stop midpoint.
    - 1: byte_done for one cycle, then IDLE.
    - 0: frame_err pulses one cycle later, the byte is discarded, and the FSM goes to IDLE. IDLE then waits for rxs==0, so a low line re-arms as a new start.
- Parser (acts on byte_done):
  - 0xF8–0xFF (real-time): ignored entirely. Parser state, running status and partial data are untouched.
  - 0xF0–0xF7 (system common / SysEx): clears running status and byte count. Following data bytes are discarded.
  - 0x80–0xEF: becomes the running status; byte count is cleared. Required data length:
    - 2 bytes for 8x, 9x, Ax, Bx, Ex.
    - 1 byte for Cx, Dx.
  - 0x00–0x7F with no running status: discarded.
  - 0x00–0x7F with running status:
    - First data byte goes to data1.
    - If the message is complete (1-byte type, or second data byte), commit and reset the byte count to 0. Running status is kept for further data bytes.
  - A status byte arriving mid-message abandons the partial message.
- Commit:
  - status, data1 and data2 update together and msg_valid pulses, both in the clock after byte_done.
  - data2 is forced to 0x00 for 1-byte types.
  - Outputs hold their values between commits.
- Latency: msg_valid is exactly 1 clk after the stop-bit sample of the final byte of a message.
- frame_err and msg_valid are never high in the same cycle.

Test Plan:
(Bench uses CLK_FREQ=1000000, BAUD=31250, so CPB=32.)
1. Reset, then send 0x90 0x3C 0x64. Required: exactly one msg_valid, with status=0x90, data1=0x3C, data2=0x64, 1 clk after the third stop-bit sample. No frame_err.
2. Continue with 0x3C 0x00 (running status). Required: a second msg_valid with status=0x90, data1=0x3C, data2=0x00. Then send 0xC5 0x07: msg_valid with status=0xC5, data1=0x07, data2=0x00.
3. Send 0xB0, 0xF8, 0x07, 0xF8, 0x7F. Required: a single msg_valid with 0xB0/0x07/0x7F. The 0xF8 bytes produce no effect.
4. Send 0x90 0x40 with the stop bit of 0x40 forced low, then 0x40 0x50. Required:
   - frame_err pulses once.
   - No msg_valid for the corrupted frame.
   - Then msg_valid with 0x90/0x40/0x50.
5. Send a low glitch of 10 clk on midi_rx_i; separately send 0xF0 0x01 0x02 0xF7 then 0x05. Required: no byte from the glitch, no msg_valid, no frame_err.
6. Assert rst asynchronously at data bit 4 of the second byte of 0x80 0x3C 0x40. Required:
   - All outputs read 0 immediately.
   - After release, 0x40 alone produces no msg_valid (running status was cleared).
   - 0x80 0x3C 0x40 then decodes correctly.
